// File: rtl/minus_dist_if.sv
// Bus between the nearest-centroid controller and its point store, centroid store,
// shared subtractor and result consumer.
interface minus_dist_if #(
    parameter int DIM = 2,
    parameter int K   = 4,
    parameter int W   = 32
);
    localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CAW = $clog2(K * DIM);
    localparam int CW  = $clog2(K);

    logic           start;
    logic           busy;
    logic           done;
    logic [AW-1:0]  pt_addr;
    logic [W-1:0]   pt_data;
    logic [CAW-1:0] cen_addr;
    logic [W-1:0]   cen_data;
    logic [W-1:0]   inputX;
    logic [W-1:0]   inputY;
    logic [W-1:0]   sum;
    logic [CW-1:0]  cluster;
    logic [W-1:0]   min_dist;

    modport slave (
        input  start, pt_data, cen_data, sum,
        output busy, done, pt_addr, cen_addr, inputX, inputY, cluster, min_dist
    );

    modport master (
        output start, pt_data, cen_data, sum,
        input  busy, done, pt_addr, cen_addr, inputX, inputY, cluster, min_dist
    );
endinterface

// File: rtl/minus_dist_ctrl.sv
// Nearest-centroid search: walks every centroid, accumulates the Manhattan distance
// through an external one-cycle subtractor and keeps the lowest-index minimum.
module minus_dist_ctrl #(
    parameter int DIM = 2,
    parameter int K   = 4,
    parameter int W   = 32
) (
    input  logic        minus_clk,
    input  logic        minus_rst,
    minus_dist_if.slave bus
);
    localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CAW = $clog2(K * DIM);
    localparam int CW  = $clog2(K);

    localparam logic [AW-1:0] DIM_LAST = AW'(DIM - 1);
    localparam logic [CW-1:0] CEN_LAST = CW'(K - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Distances never wrap: an overflowing sum pins at all-ones.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    state_t         state_q;
    logic [AW-1:0]  dim_q;
    logic [CW-1:0]  cen_q;
    logic [CAW-1:0] cen_addr_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   in_x_q;
    logic [W-1:0]   in_y_q;
    logic [CW-1:0]  cluster_q;
    logic [W-1:0]   min_dist_q;
    logic           busy_q;
    logic           done_q;

    assign acc_d = sat_add(acc_q, bus.sum);

    always_ff @(posedge minus_clk) begin
        if (minus_rst) begin
            state_q    <= IDLE;
            dim_q      <= '0;
            cen_q      <= '0;
            cen_addr_q <= '0;
            acc_q      <= '0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            cluster_q  <= '0;
            min_dist_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        dim_q      <= '0;
                        cen_q      <= '0;
                        cen_addr_q <= '0;
                        acc_q      <= '0;
                    end
                end
                ISSUE: begin
                    // Larger operand goes first so the unsigned difference is |a-b|.
                    if (bus.pt_data >= bus.cen_data) begin
                        in_x_q <= bus.pt_data;
                        in_y_q <= bus.cen_data;
                    end else begin
                        in_x_q <= bus.cen_data;
                        in_y_q <= bus.pt_data;
                    end
                    state_q <= WAIT;
                end
                WAIT: state_q <= ACC;
                ACC: begin
                    acc_q <= acc_d;
                    if (dim_q == DIM_LAST) begin
                        dim_q   <= '0;
                        state_q <= CMP;
                    end else begin
                        dim_q      <= dim_q + 1'b1;
                        cen_addr_q <= cen_addr_q + 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                CMP: begin
                    if ((cen_q == '0) || (acc_q < min_dist_q)) begin
                        cluster_q  <= cen_q;
                        min_dist_q <= acc_q;
                    end
                    acc_q <= '0;
                    if (cen_q == CEN_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cen_q      <= cen_q + 1'b1;
                        cen_addr_q <= cen_addr_q + 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pt_addr  = dim_q;
    assign bus.cen_addr = cen_addr_q;
    assign bus.inputX   = in_x_q;
    assign bus.inputY   = in_y_q;
    assign bus.cluster  = cluster_q;
    assign bus.min_dist = min_dist_q;
endmodule

// File: tb/tb_minus_dist_ctrl.sv
// Directed bench for minus_dist_ctrl with behavioural point/centroid stores and a
// registered subtractor.
module tb_minus_dist_ctrl;
    localparam int DIM = 2;
    localparam int K   = 4;
    localparam int W   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    minus_dist_if #(.DIM(DIM), .K(K), .W(W)) bus ();

    minus_dist_ctrl #(.DIM(DIM), .K(K), .W(W)) dut (
        .minus_clk (clk),
        .minus_rst (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] pt_mem  [DIM];
    logic [W-1:0] cen_mem [K*DIM];
    logic [W-1:0] sum_q = '0;

    assign bus.pt_data  = pt_mem[bus.pt_addr];
    assign bus.cen_data = cen_mem[bus.cen_addr];
    assign bus.sum      = sum_q;

    always @(posedge clk) sum_q <= bus.inputX - bus.inputY;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] px, py,
                        input logic [W-1:0] c0x, c0y, c1x, c1y,
                        input logic [W-1:0] c2x, c2y, c3x, c3y);
        pt_mem[0]  = px;  pt_mem[1]  = py;
        cen_mem[0] = c0x; cen_mem[1] = c0y;
        cen_mem[2] = c1x; cen_mem[3] = c1y;
        cen_mem[4] = c2x; cen_mem[5] = c2y;
        cen_mem[6] = c3x; cen_mem[7] = c3y;
    endtask

    function automatic logic [7:0] nonzero_flags();
        return {bus.busy != 1'b0, bus.done != 1'b0, bus.pt_addr != '0, bus.cen_addr != '0,
                bus.inputX != '0, bus.inputY != '0, bus.cluster != '0, bus.min_dist != '0};
    endfunction

    // Called at a negedge with the DUT idle. Cycle 1 is the first cycle after the
    // start-sampling edge; start/rst set in cycle n are sampled at the edge ending it.
    task automatic run_search(input int pulse_at, input int rst_at,
                              output int first_done, output int n_done,
                              output logic [W-1:0] x5, output logic [W-1:0] y5,
                              output logic [W-1:0] md8, output logic busy1,
                              output logic busy_after, output logic [7:0] rst_flags);
        first_done = 0; n_done = 0; x5 = '0; y5 = '0; md8 = '0;
        busy1 = 1'b0; busy_after = 1'b0; rst_flags = '1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            if (bus.done) begin
                n_done++;
                if (first_done == 0) first_done = n;
            end
            if (n == 1) busy1 = bus.busy;
            if (n == 5) begin x5 = bus.inputX; y5 = bus.inputY; end
            if (n == 8) md8 = bus.min_dist;
            if (n == 30 || n == 31) busy_after = busy_after | bus.busy;
            if (rst_at > 0 && n == rst_at + 1) rst_flags = nonzero_flags();
            bus.start = (n == pulse_at);
            rst       = (n == rst_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    int          fd, nd;
    logic [W-1:0] x5, y5, md8;
    logic         b1, ba;
    logic [7:0]   rf;

    initial begin
        bus.start = 1'b0;
        load(50, 13, 103, 86, 124, 40, 536, 464, 834, 21);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 64'(nonzero_flags()), 64'h0);
        rst = 1'b0;

        // Start in the first cycle after reset release.
        run_search(0, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t1_done_cycle", 64'(fd), 64'd29);
        check("t1_done_count", 64'(nd), 64'd1);
        check("t1_busy_cycle1", 64'(b1), 64'd1);
        check("t1_inputX_swap", 64'(x5), 64'd86);
        check("t1_inputY_swap", 64'(y5), 64'd13);
        check("t1_min_after_cen0", 64'(md8), 64'd126);
        check("t1_cluster", 64'(bus.cluster), 64'd1);
        check("t1_min_dist", 64'(bus.min_dist), 64'd101);

        load(0, 0, 5, 5, 10, 0, 3, 7, 20, 20);
        run_search(0, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t2_done_cycle", 64'(fd), 64'd29);
        check("t2_tie_cluster", 64'(bus.cluster), 64'd0);
        check("t2_min_dist", 64'(bus.min_dist), 64'd10);

        load(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 1, 1, 1);
        run_search(0, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t3_saturated_acc", 64'(md8), 64'hFFFF_FFFF);
        check("t3_done_count", 64'(nd), 64'd1);
        check("t3_cluster", 64'(bus.cluster), 64'd1);
        check("t3_min_dist", 64'(bus.min_dist), 64'd2);

        load(50, 13, 103, 86, 124, 40, 536, 464, 834, 21);
        run_search(5, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t4_busy_start_done_cycle", 64'(fd), 64'd29);
        check("t4_busy_start_done_count", 64'(nd), 64'd1);
        check("t4_cluster", 64'(bus.cluster), 64'd1);
        check("t4_min_dist", 64'(bus.min_dist), 64'd101);

        run_search(29, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t5_done_count", 64'(nd), 64'd1);
        check("t5_start_in_done_ignored", 64'(ba), 64'd0);

        load(0, 0, 5, 5, 10, 0, 3, 7, 20, 20);
        run_search(0, 10, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t6_reset_outputs_zero", 64'(rf), 64'h0);
        check("t6_aborted_no_done", 64'(nd), 64'd0);
        run_search(0, 0, fd, nd, x5, y5, md8, b1, ba, rf);
        check("t6_rerun_done_cycle", 64'(fd), 64'd29);
        check("t6_rerun_cluster", 64'(bus.cluster), 64'd0);
        check("t6_rerun_min_dist", 64'(bus.min_dist), 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
